sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Parametrised synchronous FIFO: next-generation buffer block for the verification environment's stimulus and scoreboard paths. Generalises width and depth, and adds:
- a first-word-fall-through (FWFT) read mode;
- runtime-programmable almost-full/almost-empty thresholds;
- a synchronous flush;
- simultaneous read/write when full.

Flags and error strobes remain registered, one-cycle status outputs.

## Interface
- FIFO_WIDTH, 16, data word width (≥1)
- FIFO_DEPTH, 8, number of entries; power of two, ≥2
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- CW (localparam), $clog2(FIFO_DEPTH)+1, count/threshold width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- data_in  in  FIFO_WIDTH  write data
- rd_en  in  1  read request
- af_thresh  in  CW  almost-full threshold
- ae_thresh  in  CW  almost-empty threshold
- data_out  out  FIFO_WIDTH  read data
- rd_valid  out  1  data_out holds valid read data
- wr_ack  out  1  previous-cycle write accepted
- overflow  out  1  previous-cycle write rejected (full)
- underflow  out  1  previous-cycle read rejected (empty)
- full, empty, almostfull, almostempty  out  1  status flags
- count  out  CW  current occupancy

## Operation
- **Reset (rst=1, async).** Pointers, count, data_out, rd_valid, wr_ack, overflow and underflow are 0. empty=1; full=0. almostempty/almostfull follow the thresholds with count=0.
- **Write accept.** wr_en && (!full || rd_en).
  - Stores data_in at wr_ptr, then wr_ptr+1; pointer wraps modulo FIFO_DEPTH.
  - Next cycle: wr_ack=1.
- **Write reject.** wr_en && full && !rd_en: no store; next cycle overflow=1, wr_ack=0.
- **Read accept.** rd_en && !empty: rd_ptr+1, with the same wrap.
  - Standard mode: data_out <= mem[rd_ptr] and rd_valid=1 on the next cycle.
  - FWFT mode: the accepted read pops the head word.
- **Read reject.** rd_en && empty: next cycle underflow=1; data_out holds its value; rd_valid=0.
  - When empty, a simultaneous write is accepted; the read is still rejected.
- **Count update.**
  - +1: accepted write without accepted read.
  - −1: accepted read without accepted write.
  - Unchanged: both accepted, or neither.
- **Flags (combinational from count).**
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - almostfull = (count ≥ af_thresh); almostempty = (count ≤ ae_thresh).
  - A threshold of 0 or greater than FIFO_DEPTH is legal; the compare is applied literally.
- **FWFT mode.** data_out = mem[rd_ptr] (combinational); rd_valid = !empty.
- **Flush.**
  - Sets pointers and count to 0 next cycle, and clears wr_ack, overflow, underflow and rd_valid.
  - Takes priority over wr_en/rd_en in the same cycle; memory contents are not cleared.

## Timing
- Write to readable latency: 1 cycle. Word written at edge N: empty=0 after edge N.
  - FWFT: data_out shows the word after edge N.
  - Standard: rd_en in cycle N+1 gives data_out after edge N+1.
- wr_ack, overflow and underflow are single-cycle pulses registered on the edge that evaluates the request. They stay high on consecutive cycles while the condition repeats.
- Standard read latency: 1 cycle; rd_valid drops the cycle after no accepted read.
- Reset asserted mid-operation: all state returns to reset values immediately; the first request after rst deasserts is evaluated on the next rising edge.
- Thresholds are sampled continuously; changing one affects the flags in the same cycle.

## Structure
- Shared package fifo_pkg holds:
  - default constants FIFO_WIDTH_DEF=16, FIFO_DEPTH_DEF=8;
  - fifo_mode_e {FIFO_STD, FIFO_FWFT};
  - function cnt_w(depth) returning $clog2(depth)+1.
- One sub-module, fifo_mem: FIFO_DEPTH×FIFO_WIDTH array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic, plus the output registers, stay in sync_fifo_prog.

## Test plan
- **Reset.** Reset mid-stream with 5 entries → count=0, empty=1, all strobes 0 in the same cycle; the next write of 0xA5A5 then reads back 0xA5A5.
- **Fill and overflow.** Default parameters, 8 writes of 1..8, then a 9th write alone → full=1 after the 8th write; overflow=1 for one cycle; count=8; reads return 1..8 in order, wrapping through pointer 0.
- **Simultaneous at full.** wr_en=rd_en=1 with 0x55 → count stays 8; 0x55 is read back after the 7 older words; overflow=0.
- **Simultaneous at empty.** wr_en=rd_en=1 with 0x77 → underflow=1, wr_ack=1, count=1; a following read returns 0x77.
- **Thresholds.** af_thresh=6, ae_thresh=2 → almostempty 1 for count 0–2; almostfull 1 for count 6–8; change af_thresh to 3 at count=4 → almostfull rises in the same cycle.
- **FWFT and flush.** FWFT=1, write 0x11 then 0x22 → data_out=0x11 with rd_valid=1 one cycle after the first write; read gives data_out=0x22; flush with wr_en=1 → count=0, empty=1, write ignored.

Source files
------------

// File: rtl/sync_fifo_prog_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable synchronous FIFO and its storage
// array.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default word width and entry count
//   fifo_mode_e                     : standard registered read or FWFT
//   cnt_w(depth)                    : width of count/threshold buses, wide
//                                     enough to hold the value "depth"
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // One extra bit over the pointer width, so that a completely full FIFO
    // (count == depth) can be represented.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Storage array for sync_fifo_prog: DEPTH words of WIDTH bits, one
// synchronous write port and one asynchronous (combinational) read port.
//   clk     : write clock, rising edge
//   wr_en   : write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : contents of mem[rd_addr], combinational
// The array has no reset; the FIFO control logic never exposes a location
// that has not been written since the last reset or flush.
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per clock when the controller accepts a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the controller can either register the
    // word (standard mode) or present it directly (first-word-fall-through).
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
// Parametrised synchronous FIFO with selectable standard / first-word-fall-
// through read, runtime almost-full/almost-empty thresholds, synchronous
// flush and simultaneous read/write while full.
//
// Parameters
//   FIFO_WIDTH : data word width (>= 1)
//   FIFO_DEPTH : number of entries, power of two, >= 2
//   FWFT       : 0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   flush       : synchronous clear of pointers/count/strobes (overrides
//                 wr_en and rd_en in the same cycle)
//   wr_en       : write request, data_in stored if accepted
//   data_in     : write data
//   rd_en       : read request
//   af_thresh   : almostfull  = (count >= af_thresh)
//   ae_thresh   : almostempty = (count <= ae_thresh)
//   data_out    : read data (registered in standard mode, head word in FWFT)
//   rd_valid    : data_out holds valid read data
//   wr_ack      : write of the previous cycle was accepted
//   overflow    : write of the previous cycle was rejected because full
//   underflow   : read of the previous cycle was rejected because empty
//   full, empty, almostfull, almostempty : status flags decoded from count
//   count       : current occupancy, 0 .. FIFO_DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    input  logic [cnt_w(FIFO_DEPTH)-1:0]  af_thresh,
    input  logic [cnt_w(FIFO_DEPTH)-1:0]  ae_thresh,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          full,
    output logic                          empty,
    output logic                          almostfull,
    output logic                          almostempty,
    output logic [cnt_w(FIFO_DEPTH)-1:0]  count
);

    localparam int              CW      = cnt_w(FIFO_DEPTH);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam fifo_mode_e      MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_next;
    logic                   wr_accept;
    logic                   rd_accept;
    logic                   wr_ack_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic [FIFO_WIDTH-1:0]  mem_rd_data;

    // Status flags are decoded from the registered count, so they change
    // only on clock edges except when a threshold input itself changes.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_thresh);
    assign almostempty = (count_q <= ae_thresh);
    assign count       = count_q;

    // A write is still accepted when full if a read frees a slot on the same
    // edge; in that case the write lands in the slot being read, which is
    // safe because the read port sampled the old word before the edge.
    // Flush wins over both requests.
    assign wr_accept = wr_en && (!full || rd_en) && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    // Occupancy moves by one only when exactly one side is accepted.
    always_comb begin
        count_next = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // Pointers and count. Depth is a power of two, so the pointers wrap by
    // natural overflow of their AW-bit width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_next;
        end
    end

    // Request outcome strobes: each reflects the request seen on the edge
    // that registered it, so they repeat on consecutive cycles while the
    // same condition persists. An empty FIFO rejects a read even when a
    // write is accepted alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_accept;
            overflow_q  <= wr_en && !wr_accept;
            underflow_q <= rd_en && empty;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // The head word is always on data_out; a read just advances
            // rd_ptr so the next word falls through after the edge.
            assign data_out = mem_rd_data;
            assign rd_valid = !empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] data_q;
            logic                  valid_q;

            // Registered read: data_out updates only on an accepted read and
            // otherwise holds its last value; rd_valid marks the cycle after
            // each accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_accept;
                    if (rd_accept) begin
                        data_q <= mem_rd_data;
                    end
                end
            end

            assign data_out = data_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_prog
// Drives one standard-mode and one FWFT-mode sync_fifo_prog with identical
// stimulus. A queue-based model of the FIFO contents predicts each cycle's
// occupancy, strobes and head word; the predictions and the expected
// standard-mode read words are queued and a negedge monitor compares them
// against both instances.
// ---------------------------------------------------------------------------
module tb_sync_fifo_prog;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;

    typedef struct {
        int           cnt;
        bit           ack;
        bit           ovf;
        bit           unf;
        bit           rdv;
        logic [W-1:0] head;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  data_in;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;

    logic [W-1:0]  s_data_out, f_data_out;
    logic          s_rd_valid, f_rd_valid;
    logic          s_wr_ack, f_wr_ack;
    logic          s_overflow, f_overflow;
    logic          s_underflow, f_underflow;
    logic          s_full, f_full;
    logic          s_empty, f_empty;
    logic          s_af, f_af;
    logic          s_ae, f_ae;
    logic [CW-1:0] s_count, f_count;

    logic [W-1:0]  model[$];
    logic [W-1:0]  exp_data_q[$];
    exp_t          exp_stat_q[$];
    exp_t          mon_e;
    logic [W-1:0]  mon_d;

    int checks = 0;
    int errors = 0;

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .data_out(s_data_out), .rd_valid(s_rd_valid), .wr_ack(s_wr_ack),
        .overflow(s_overflow), .underflow(s_underflow), .full(s_full),
        .empty(s_empty), .almostfull(s_af), .almostempty(s_ae), .count(s_count)
    );

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .wr_ack(f_wr_ack),
        .overflow(f_overflow), .underflow(f_underflow), .full(f_full),
        .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of requests, then advances the model across the edge
    // and queues what both instances should show after it.
    task automatic applyStimulus(input bit wr, input logic [W-1:0] din,
                                 input bit rd, input bit fl);
        exp_t e;
        bit   wacc;
        bit   racc;
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        flush   = fl;
        @(posedge clk);
        if (fl) begin
            model.delete();
            e.ack = 0;
            e.ovf = 0;
            e.unf = 0;
            e.rdv = 0;
        end else begin
            wacc = wr && ((model.size() < D) || rd);
            racc = rd && (model.size() > 0);
            if (racc) exp_data_q.push_back(model.pop_front());
            if (wacc) model.push_back(din);
            e.ack = wacc;
            e.ovf = wr && !wacc;
            e.unf = rd && !racc;
            e.rdv = racc;
        end
        e.cnt  = model.size();
        e.head = (model.size() > 0) ? model[0] : '0;
        exp_stat_q.push_back(e);
        #1;
    endtask

    // Asserts reset away from any edge and checks the immediate effect.
    task automatic doReset();
        @(negedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("rst_count_std", 32'(s_count), 0);
        checkOutput("rst_count_fwft", 32'(f_count), 0);
        checkOutput("rst_empty", 32'(s_empty), 1);
        checkOutput("rst_full", 32'(s_full), 0);
        checkOutput("rst_strobes_std", {s_wr_ack, s_overflow, s_underflow, s_rd_valid}, 0);
        checkOutput("rst_strobes_fwft", {f_wr_ack, f_overflow, f_underflow, f_rd_valid}, 0);
        checkOutput("rst_data_std", 32'(s_data_out), 0);
        checkOutput("rst_ae", 32'(s_ae), 1);
        checkOutput("rst_af", 32'(s_af), (af_thresh == 0) ? 1 : 0);
        model.delete();
        exp_data_q.delete();
        exp_stat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares queued predictions whenever the DUTs present a cycle
    // of status, and pops an expected word whenever standard mode shows data.
    always @(negedge clk) begin
        if (!rst && exp_stat_q.size() > 0) begin
            mon_e = exp_stat_q.pop_front();
            checkOutput("count_std", 32'(s_count), 32'(mon_e.cnt));
            checkOutput("count_fwft", 32'(f_count), 32'(mon_e.cnt));
            checkOutput("empty", 32'(s_empty), (mon_e.cnt == 0) ? 1 : 0);
            checkOutput("full", 32'(s_full), (mon_e.cnt == D) ? 1 : 0);
            checkOutput("almostfull", 32'(s_af), (mon_e.cnt >= int'(af_thresh)) ? 1 : 0);
            checkOutput("almostempty", 32'(s_ae), (mon_e.cnt <= int'(ae_thresh)) ? 1 : 0);
            checkOutput("wr_ack", 32'(s_wr_ack), 32'(mon_e.ack));
            checkOutput("overflow", 32'(s_overflow), 32'(mon_e.ovf));
            checkOutput("underflow", 32'(s_underflow), 32'(mon_e.unf));
            checkOutput("rd_valid_std", 32'(s_rd_valid), 32'(mon_e.rdv));
            checkOutput("strobes_fwft", {f_wr_ack, f_overflow, f_underflow},
                        {mon_e.ack, mon_e.ovf, mon_e.unf});
            checkOutput("rd_valid_fwft", 32'(f_rd_valid), (mon_e.cnt > 0) ? 1 : 0);
            if (mon_e.cnt > 0) begin
                checkOutput("fwft_data", 32'(f_data_out), 32'(mon_e.head));
            end
        end
        if (!rst && s_rd_valid) begin
            if (exp_data_q.size() == 0) begin
                checkOutput("std_read_unexpected", 32'(s_rd_valid), 0);
            end else begin
                mon_d = exp_data_q.pop_front();
                checkOutput("std_read_data", 32'(s_data_out), 32'(mon_d));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        data_in   = '0;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        doReset();

        // Reset in the middle of traffic with five words stored.
        for (int i = 0; i < 5; i++) applyStimulus(1, W'($urandom), 0, 0);
        doReset();
        applyStimulus(1, 16'hA5A5, 0, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        // Fill to full (pointers start at 1, so this wraps through 0),
        // then a lone write that must overflow.
        for (int i = 1; i <= 8; i++) applyStimulus(1, W'(i), 0, 0);
        applyStimulus(1, 16'h0099, 0, 0);
        applyStimulus(0, '0, 0, 0);

        // Simultaneous read and write while full, then drain.
        applyStimulus(1, 16'h0055, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 1, 0);

        // Simultaneous read and write while empty.
        applyStimulus(1, 16'h0077, 1, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        // Thresholds: walk occupancy up, lower af_thresh at count 4.
        for (int i = 0; i < 4; i++) applyStimulus(1, W'($urandom), 0, 0);
        af_thresh = 4'd3;
        applyStimulus(0, '0, 0, 0);
        af_thresh = 4'd6;
        for (int i = 0; i < 4; i++) applyStimulus(1, W'($urandom), 0, 0);
        af_thresh = 4'd0;
        ae_thresh = 4'd15;
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, 1, 0);
        af_thresh = 4'd9;
        ae_thresh = 4'd0;
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);
        af_thresh = 4'd6;
        ae_thresh = 4'd2;

        // Fall-through head word, read, then flush alongside a write.
        applyStimulus(1, 16'h0011, 0, 0);
        applyStimulus(1, 16'h0022, 0, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(1, 16'h0033, 0, 1);
        applyStimulus(0, '0, 0, 0);

        // Randomised traffic with occasional flushes and threshold changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                af_thresh = CW'($urandom_range(0, 15));
                ae_thresh = CW'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 99) < 55, W'($urandom),
                          $urandom_range(0, 99) < 50, $urandom_range(0, 39) == 0);
        end

        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        for (int i = 0; i < 10; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("read_queue_drained", exp_data_q.size(), 0);
        checkOutput("status_queue_drained", exp_stat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
